alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
//  Drives the 4-bit combinational arithmetic ALU slice nibble-serially over WIDTH-bit operands.
//  Feeds the slice's carry-out back as the next nibble's carry-in, assembling a wide result.
//  Placed between the register/host front end (valid/ready) and the ALU slice (external ports).
// PARAMETERS
//  WIDTH  16  operand/result width; multiple of 4, >=4; NIBBLES = WIDTH/4 (localparam)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      async active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid&in_ready
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_s       in   4      ALU select (held for whole op)
//  in_cn      in   1      carry-in to nibble 0 (active-high: +1)
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      result consumed when out_valid&out_ready
//  out_f      out  WIDTH  result
//  out_cout   out  1      raw carry-out (alu_cn4) of the MSB nibble
//  alu_a      out  4      current A nibble to slice
//  alu_b      out  4      current B nibble to slice
//  alu_s      out  4      latched select to slice
//  alu_cn     out  1      current carry-in to slice
//  alu_f      in   4      slice result (combinational, same cycle)
//  alu_cn4    in   1      slice carry-out (combinational, same cycle)
// BEHAVIOUR
//  FSM IDLE -> RUN -> DONE -> IDLE; async reset -> IDLE, regs zero.
//  in_ready = (state==IDLE), so it reads 1 during and after reset; out_valid = (state==DONE).
//  Reset values: out_valid=0, out_f=0, out_cout=0; alu_a/alu_b/alu_s=0, alu_cn=0.
//  IDLE: on in_valid -> latch a,b,s,cn into shift regs, carry<=in_cn, cnt<=0, go RUN.
//  RUN: alu_a/alu_b = LSB nibble of A/B shift regs; alu_s = latched s; alu_cn = carry reg.
//    Each cycle: shift alu_f into result MSB end; shift A/B right by 4; cnt++.
//    Carry update: carry <= is_borrow_op(s) ? ~alu_cn4 : alu_cn4.
//    Raw alu_cn4 is always stored in the cout reg.
//  RUN exit: cnt==NIBBLES-1 -> DONE. out_valid rises exactly NIBBLES cycles after the accept edge.
//  DONE: out_f/out_cout held stable; in_valid ignored; on out_ready -> IDLE.
//    The next request is accepted no earlier than the following cycle (no same-cycle turnaround).
//  Borrow ops (s = 0011, 0110, 0111, 1011, 1111; the "-1" rows) chain on the inverted carry.
//    This makes wide A-B (cn=1) and A-1 (cn=0) correct. All other selects chain raw carry.
//  Outside RUN, alu_* hold their last values (not functionally used).
//  Reset mid-RUN/DONE: abort immediately, discard op, outputs to reset values.
//  Width rules: all nibble math lives in the slice; block adds no arithmetic beyond carry inversion.
// CONFIGURATION
//  ALU_SEQ_FLAGS_EN defined: adds out_zero (out_f==0) and out_sign (out_f[WIDTH-1]).
//    Both are registered at DONE entry, reset 0, held with out_f.
//  ALU_SEQ_FLAGS_EN undefined: these ports and registers do not exist.
// STRUCTURE
//  Package alu_seq_pkg:
//    state_t enum {IDLE, RUN, DONE}
//    BORROW_OPS constants
//    function is_borrow_op(logic [3:0] s)
//  No sub-module. The ALU slice is instantiated beside this block at chip top.
// TESTING (WIDTH=16, bench ties slice model to alu_* ports)
//  1 s=1001 a=0x1234 b=0x0FFF cn=0 -> out_f=0x2233 cout=0; out_valid 4 cycles after accept
//  2 s=1001 a=0xFFFF b=0x0001 cn=0 -> out_f=0x0000 cout=1 (out_zero=1 if FLAGS_EN)
//  3 s=0110 a=0x1000 b=0x0001 cn=1 -> out_f=0x0FFF cout=0
//    alu_cn per nibble: 1,0,0,0
//  4 s=1111 a=0x0000 cn=0 -> out_f=0xFFFF cout=1 (out_sign=1 if FLAGS_EN)
//  5 hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_f stable, in_ready=0
//    Then handshake -> IDLE; next op accepted the cycle after.
//  6 assert rst_n=0 at RUN cnt==2 -> out_valid=0, out_f=0 at once; in_ready=1; fresh op correct

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared state encoding and select classification for the nibble-serial ALU sequencer.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The "-1" rows of the slice: their carry-out flags a borrow, so the chain uses its inverse.
   localparam logic [3:0] OP_MINUS_ONE   = 4'b0011;
   localparam logic [3:0] OP_A_MINUS_B   = 4'b0110;
   localparam logic [3:0] OP_ANB_MINUS_1 = 4'b0111;
   localparam logic [3:0] OP_AB_MINUS_1  = 4'b1011;
   localparam logic [3:0] OP_A_MINUS_1   = 4'b1111;

   function automatic logic is_borrow_op(input logic [3:0] s);
      return (s == OP_MINUS_ONE)   || (s == OP_A_MINUS_B) ||
             (s == OP_ANB_MINUS_1) || (s == OP_AB_MINUS_1) ||
             (s == OP_A_MINUS_1);
   endfunction

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Chains a 4-bit ALU slice over WIDTH bits, one nibble per cycle; result NIBBLES cycles after accept,
// held until out_ready, no new request taken until DONE drains. ALU_SEQ_FLAGS_EN adds out_zero/out_sign.
module alu_nibble_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_s,
   input  logic             in_cn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_f,
   output logic             out_cout,
`ifdef ALU_SEQ_FLAGS_EN
   output logic             out_zero,
   output logic             out_sign,
`endif
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_s,
   output logic             alu_cn,
   input  logic [3:0]       alu_f,
   input  logic             alu_cn4
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [3:0]       s_q, s_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ALU_SEQ_FLAGS_EN
   logic             zero_q, zero_d;
   logic             sign_q, sign_d;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
`ifdef ALU_SEQ_FLAGS_EN
      zero_d  = zero_q;
      sign_d  = sign_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
               a_d     = in_a;
               b_d     = in_b;
               s_d     = in_s;
               carry_d = in_cn;
               cnt_d   = '0;
            end
         end
         RUN: begin
            res_d  = (res_q >> 4) | (WIDTH'(alu_f) << (WIDTH - 4));
            cout_d = alu_cn4;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(NIBBLES - 1)) begin
               // Operand and carry regs are left alone on the last nibble so alu_* hold.
               state_d = DONE;
`ifdef ALU_SEQ_FLAGS_EN
               zero_d  = (res_d == '0);
               sign_d  = res_d[WIDTH-1];
`endif
            end else begin
               a_d     = a_q >> 4;
               b_d     = b_q >> 4;
               carry_d = is_borrow_op(s_q) ? ~alu_cn4 : alu_cn4;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
         zero_q  <= 1'b0;
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
`ifdef ALU_SEQ_FLAGS_EN
         zero_q  <= zero_d;
         sign_q  <= sign_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_f     = res_q;
   assign out_cout  = cout_q;
`ifdef ALU_SEQ_FLAGS_EN
   assign out_zero  = zero_q;
   assign out_sign  = sign_q;
`endif
   assign alu_a     = a_q[3:0];
   assign alu_b     = b_q[3:0];
   assign alu_s     = s_q;
   assign alu_cn    = carry_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench: 4-bit slice model on alu_* ports, wide-integer reference model for results.
module tb_alu_nibble_sequencer;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready;
   logic [WIDTH-1:0] in_a, in_b;
   logic [3:0]       in_s;
   logic             in_cn;
   logic             out_valid, out_ready;
   logic [WIDTH-1:0] out_f;
   logic             out_cout;
`ifdef ALU_SEQ_FLAGS_EN
   logic             out_zero, out_sign;
`endif
   logic [3:0]       alu_a, alu_b, alu_s, alu_f;
   logic             alu_cn, alu_cn4;

   alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_cn(in_cn),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_f(out_f), .out_cout(out_cout),
`ifdef ALU_SEQ_FLAGS_EN
      .out_zero(out_zero), .out_sign(out_sign),
`endif
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cn(alu_cn),
      .alu_f(alu_f), .alu_cn4(alu_cn4)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Arithmetic-mode function table of the slice, evaluated at any width via mask.
   // Borrow rows compute X-1+cn and report carry-out when the value goes negative.
   function automatic void op_value(input longint a, input longint b, input logic [3:0] s,
                                    input logic cn, input longint mask,
                                    output longint v, output bit brw);
      longint nb;
      longint x;
      nb  = ~b & mask;
      brw = 1'b0;
      x   = 0;
      case (s)
         4'h0: x = a;
         4'h1: x = a | b;
         4'h2: x = a | nb;
         4'h3: begin x = 0;      brw = 1'b1; end
         4'h4: x = a + (a & nb);
         4'h5: x = (a | b) + (a & nb);
         4'h6: begin x = a - b;  brw = 1'b1; end
         4'h7: begin x = a & nb; brw = 1'b1; end
         4'h8: x = a + (a & b);
         4'h9: x = a + b;
         4'hA: x = (a | nb) + (a & b);
         4'hB: begin x = a & b;  brw = 1'b1; end
         4'hC: x = a + a;
         4'hD: x = (a | b) + a;
         4'hE: x = (a | nb) + a;
         default: begin x = a;   brw = 1'b1; end
      endcase
      v = brw ? (x - 1 + longint'(cn)) : (x + longint'(cn));
   endfunction

   longint slice_v;
   bit     slice_br;
   always_comb begin
      slice_v  = 0;
      slice_br = 1'b0;
      op_value(longint'(alu_a), longint'(alu_b), alu_s, alu_cn, 64'd15, slice_v, slice_br);
      alu_f   = 4'(slice_v & 64'd15);
      alu_cn4 = slice_br ? (slice_v < 0) : (slice_v > 15);
   end

   function automatic void ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [3:0] s, input logic cn,
                                     output logic [WIDTH-1:0] f, output logic cout);
      longint v;
      bit     br;
      longint mask;
      mask = (64'd1 << WIDTH) - 1;
      op_value(longint'(a), longint'(b), s, cn, mask, v, br);
      f    = WIDTH'(v & mask);
      cout = br ? (v < 0) : (v > mask);
   endfunction

   typedef struct {
      logic [WIDTH-1:0] f;
      logic             cout;
      int               acc;
   } exp_t;
   exp_t sb[$];

   // 0: random out_ready, 1: hold low, 2: hold high
   int ready_mode = 0;
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 1)      out_ready = 1'b0;
         else if (ready_mode == 2) out_ready = 1'b1;
         else                      out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops on each new result, then checks it stays put until consumed.
   bit               seen = 1'b0;
   logic [WIDTH-1:0] hold_f;
   logic             hold_c;
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (!seen) begin
            seen   = 1'b1;
            hold_f = out_f;
            hold_c = out_cout;
            if (sb.size() == 0) begin
               chk("unexpected_result", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_f", out_f, e.f);
               chk("out_cout", out_cout, e.cout);
               chk("latency", cyc - e.acc, NIB);
`ifdef ALU_SEQ_FLAGS_EN
               chk("out_zero", out_zero, e.f == '0);
               chk("out_sign", out_sign, e.f[WIDTH-1]);
`endif
            end
         end else begin
            chk("hold_f", out_f, hold_f);
            chk("hold_cout", out_cout, hold_c);
         end
         if (out_ready) seen = 1'b0;
      end
   end

   task automatic push_exp(input logic [WIDTH-1:0] f, input logic cout);
      exp_t e;
      e.f    = f;
      e.cout = cout;
      e.acc  = cyc + 1;
      sb.push_back(e);
   endtask

   // Presents a request at a negedge, waits for acceptance, returns 1 ns after the accept edge.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [3:0] s,
                        input logic cn, input logic [WIDTH-1:0] ef, input logic ec);
      int n;
      @(negedge clk);
      in_a = a; in_b = b; in_s = s; in_cn = cn; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'd0, 64'd1);
      end else begin
         push_exp(ef, ec);
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic issue_rand();
      logic [WIDTH-1:0] a, b, f;
      logic [3:0]       s;
      logic             cn, c;
      a  = WIDTH'($urandom);
      b  = WIDTH'($urandom);
      s  = 4'($urandom_range(0, 15));
      cn = 1'($urandom_range(0, 1));
      ref_model(a, b, s, cn, f, c);
      issue(a, b, s, cn, f, c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [3:0] exp_cn [4];
      int         n;
      rst_n = 1'b1; in_valid = 1'b0;
      in_a = '0; in_b = '0; in_s = '0; in_cn = 1'b0;
      #3 rst_n = 1'b0;
      #5;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_f", out_f, 0);
      chk("rst_out_cout", out_cout, 0);
      chk("rst_alu_abs", {alu_a, alu_b, alu_s}, 0);
      chk("rst_alu_cn", alu_cn, 0);
`ifdef ALU_SEQ_FLAGS_EN
      chk("rst_flags", {out_zero, out_sign}, 0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 16'h2233, 1'b0);
      issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 16'h0000, 1'b1);
      wait_drain();

      exp_cn[0] = 4'd1; exp_cn[1] = 4'd0; exp_cn[2] = 4'd0; exp_cn[3] = 4'd0;
      issue(16'h1000, 16'h0001, 4'b0110, 1'b1, 16'h0FFF, 1'b0);
      chk("alu_cn_nib0", alu_cn, exp_cn[0]);
      for (int k = 1; k < 4; k++) begin
         @(posedge clk);
         #1 chk("alu_cn_nib", alu_cn, exp_cn[k]);
      end
      issue(16'h0000, 16'h5A5A, 4'b1111, 1'b0, 16'hFFFF, 1'b1);
      wait_drain();

      // DONE held with a pending request, then handshake and turnaround.
      ready_mode = 1;
      issue(16'h00FF, 16'h0F01, 4'b1001, 1'b1, 16'h1001, 1'b0);
      @(negedge clk);
      in_a = 16'h4321; in_b = 16'h1111; in_s = 4'b0110; in_cn = 1'b1; in_valid = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("done_reached", out_valid, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("done_in_ready", in_ready, 0);
         chk("done_out_valid", out_valid, 1);
      end
      ready_mode = 2;
      n = 0;
      while (out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("turnaround_in_ready", in_ready, 1);
      push_exp(16'h3210, 1'b0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      ready_mode = 0;
      wait_drain();

      // Reset while RUN is on its third nibble.
      issue(16'hABCD, 16'h1234, 4'b1001, 1'b0, 16'hBE01, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_f", out_f, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_cout", out_cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(16'h8000, 16'h0001, 4'b0110, 1'b1, 16'h7FFF, 1'b0);
      wait_drain();

      for (int i = 0; i < 40; i++) issue_rand();
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
